// File: rtl/gpu_mode_sequencer.sv
// Scanline/frame sequencer: dot/line counters, LCD mode walk (OAM -> transfer -> HBLANK, then VBLANK),
// microcode start/abort/done handshake and the VBLANK/STAT interrupt pulses.
module gpu_mode_sequencer #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int LINES_VISIBLE = 144,
  parameter int LINES_TOTAL   = 154
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iLcdEnable,
  input  logic [7:0] iLyc,
  input  logic [3:0] iStatIe,
  input  logic       iUcodeDone,
  output logic       oUcodeStart,
  output logic       oUcodeAbort,
  output logic [1:0] oMode,
  output logic [7:0] oLy,
  output logic [8:0] oDot,
  output logic       oCoincidence,
  output logic       oVblankIrq,
  output logic       oStatIrq,
  output logic       oOverrun
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_OAM,
    ST_XFER,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  localparam logic [8:0] DOT_LAST     = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DOT_OAM_LAST = 9'(OAM_DOTS - 1);
  localparam logic [7:0] LY_VBLANK    = 8'(LINES_VISIBLE);
  localparam logic [7:0] LY_LAST      = 8'(LINES_TOTAL - 1);

  state_t     state_q, state_d;
  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic [1:0] mode_q, mode_d;
  logic       start_q, start_d;
  logic       abort_q, abort_d;
  logic       overrun_q, overrun_d;
  logic       coin_q, coin_d;
  logic       stat_q, stat_d;
  logic       stat_irq_q, stat_irq_d;
  logic       vblank_irq_q, vblank_irq_d;
  logic       eol;
  logic       line_end;
  logic [7:0] ly_inc;

  always_comb begin
    state_d   = state_q;
    dot_d     = dot_q;
    ly_d      = ly_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    overrun_d = overrun_q;
    line_end  = 1'b0;
    eol       = (dot_q == DOT_LAST);
    ly_inc    = ly_q + 8'd1;

    if (!iLcdEnable) begin
      state_d   = ST_OFF;
      dot_d     = '0;
      ly_d      = '0;
      abort_d   = (state_q == ST_XFER);
      overrun_d = 1'b0;
    end else if (state_q == ST_OFF) begin
      state_d = ST_OAM;
      dot_d   = '0;
      ly_d    = '0;
    end else begin
      dot_d = eol ? 9'd0 : dot_q + 9'd1;
      case (state_q)
        ST_OAM: begin
          if (dot_q == DOT_OAM_LAST) begin
            state_d = ST_XFER;
            start_d = 1'b1;
          end
        end
        ST_XFER: begin
          // End of line always wins over a late done; only a missing done is an overrun.
          if (eol) begin
            line_end  = 1'b1;
            overrun_d = overrun_q | ~iUcodeDone;
          end else if (iUcodeDone && !start_q) begin
            state_d = ST_HBLANK;
          end
        end
        ST_HBLANK: line_end = eol;
        ST_VBLANK: begin
          if (eol) begin
            if (ly_q == LY_LAST) begin
              ly_d    = '0;
              state_d = ST_OAM;
            end else begin
              ly_d = ly_inc;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
      if (line_end) begin
        ly_d    = ly_inc;
        state_d = (ly_inc == LY_VBLANK) ? ST_VBLANK : ST_OAM;
      end
    end

    case (state_d)
      ST_OAM:    mode_d = 2'd2;
      ST_XFER:   mode_d = 2'd3;
      ST_VBLANK: mode_d = 2'd1;
      default:   mode_d = 2'd0;
    endcase

    // Coincidence follows the line number one cycle late, so a new line starts from the old compare.
    coin_d       = (state_d != ST_OFF) && (ly_q == iLyc);
    stat_d       = ((state_d == ST_HBLANK) & iStatIe[0]) | ((state_d == ST_VBLANK) & iStatIe[1]) |
                   ((state_d == ST_OAM) & iStatIe[2]) | (coin_d & iStatIe[3]);
    stat_irq_d   = stat_d & ~stat_q;
    vblank_irq_d = (state_d == ST_VBLANK) && (state_q != ST_VBLANK);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= ST_OFF;
      dot_q        <= '0;
      ly_q         <= '0;
      mode_q       <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      overrun_q    <= 1'b0;
      coin_q       <= 1'b0;
      stat_q       <= 1'b0;
      stat_irq_q   <= 1'b0;
      vblank_irq_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dot_q        <= dot_d;
      ly_q         <= ly_d;
      mode_q       <= mode_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      overrun_q    <= overrun_d;
      coin_q       <= coin_d;
      stat_q       <= stat_d;
      stat_irq_q   <= stat_irq_d;
      vblank_irq_q <= vblank_irq_d;
    end
  end

  assign oUcodeStart  = start_q;
  assign oUcodeAbort  = abort_q;
  assign oMode        = mode_q;
  assign oLy          = ly_q;
  assign oDot         = dot_q;
  assign oCoincidence = coin_q;
  assign oVblankIrq   = vblank_irq_q;
  assign oStatIrq     = stat_irq_q;
  assign oOverrun     = overrun_q;

endmodule
